aes128_cipher_unrolled: RTL and testbench

Iterative AES-128 encryption core with a valid/ready handshake on both sides and a compile-time unroll factor of 1, 2, 5 or 10 rounds per clock. Round keys are expanded on the fly inside the block, so no external key-expansion module is needed. The block sits between the CMAC controller and the subkey/MAC datapath and replaces the fixed 11-cycle, `ld`/`Done` cipher. It accepts one block at a time and holds its result until the consumer takes it.

---
 rtl/aes128_cipher_unrolled.sv | 256 +++++++++++++++++++++++++
 tb/tb_aes128_cipher_unrolled.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_cipher_unrolled.sv
// -----------------------------------------------------------------------------
// aes128_cipher_unrolled
//
// Iterative AES-128 encryption core. Round keys are expanded on the fly, so no
// external key schedule is needed. UNROLL (1, 2, 5 or 10) rounds are evaluated
// combinationally per clock, so a block takes 10/UNROLL cycles in RUN.
//
// Optional feature (compile-time macro): AES_OUT_REG_EN
//   Defined   : TextOut comes from a dedicated output register that is loaded
//               on the RUN->DONE transition (one extra cycle of latency).
//   Undefined : TextOut is the round-state register itself. It shows
//               intermediate round values during RUN.
//
// Ports
//   CLK        in   clock, rising edge
//   Rst_n      in   synchronous active-low reset (aborts any block in flight)
//   in_valid   in   KEY/TextIn valid
//   in_ready   out  high only in IDLE
//   KEY        in   128-bit cipher key, byte 0 = KEY[127:120]
//   TextIn     in   128-bit plaintext, same byte order
//   out_valid  out  TextOut holds a ciphertext (DONE)
//   out_ready  in   consumer takes TextOut
//   TextOut    out  128-bit ciphertext
//   busy       out  high in RUN or DONE
//
// Also contains aes_sbox, the byte substitution cell (GF(2^8) inverse over
// 0x11b followed by the FIPS-197 affine transform), so this file stands alone.
// -----------------------------------------------------------------------------

module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  always_comb begin
    x2   = gf_mul(din, din);
    x3   = gf_mul(x2, din);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes128_cipher_unrolled #(
  parameter int UNROLL = 1
) (
  input  logic         CLK,
  input  logic         Rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] KEY,
  input  logic [127:0] TextIn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] TextOut,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_cipher_unrolled: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
`ifdef AES_OUT_REG_EN
  logic [127:0] out_q, out_d;
`endif

  logic [127:0] rounds_state;
  logic [127:0] rounds_key;
  logic [7:0]   rounds_rcon;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Chain of UNROLL round slices. Each slice owns its signals and reads the
  // previous slice by name, so the chain never folds back onto one variable.
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [127:0] s_in, k_in, sb, sr, mc, s_out, k_out;
    logic [7:0]   c_in, c_out;
    logic [31:0]  rot, ksub, w0, w1, w2, w3;
    logic         last;

    if (g == 0) begin : g_src
      assign s_in = state_q;
      assign k_in = rkey_q;
      assign c_in = rcon_q;
    end else begin : g_src
      assign s_in = g_round[g-1].s_out;
      assign k_in = g_round[g-1].k_out;
      assign c_in = g_round[g-1].c_out;
    end

    // RotWord of the last key word; SubWord applied by the key S-boxes.
    assign rot = {k_in[23:0], k_in[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_ksbox
      aes_sbox u_sbox (.din(rot[8*b +: 8]), .dout(ksub[8*b +: 8]));
    end

    for (genvar b = 0; b < 16; b++) begin : g_ssbox
      aes_sbox u_sbox (.din(s_in[8*b +: 8]), .dout(sb[8*b +: 8]));
    end

    // rnd_q is always a multiple of UNROLL, so slice g runs round rnd_q+g+1.
    assign last = (rnd_q == 4'(9 - g));

    always_comb begin
      w0    = k_in[127:96] ^ ksub ^ {c_in, 24'h000000};
      w1    = k_in[95:64] ^ w0;
      w2    = k_in[63:32] ^ w1;
      w3    = k_in[31:0] ^ w2;
      k_out = {w0, w1, w2, w3};
      c_out = xtime(c_in);

      // ShiftRows on column-major bytes: row r rotates left by r columns.
      sr = '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          sr[127 - 8*(r + 4*c) -: 8] = sb[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        end
      end

      mc = '0;
      for (int c = 0; c < 4; c++) begin
        mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
      end

      s_out = (last ? sr : mc) ^ k_out;
    end
  end

  assign rounds_state = g_round[UNROLL-1].s_out;
  assign rounds_key   = g_round[UNROLL-1].k_out;
  assign rounds_rcon  = g_round[UNROLL-1].c_out;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
`ifdef AES_OUT_REG_EN
    out_d   = out_q;
`endif
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = TextIn ^ KEY;
          rkey_d  = KEY;
          rcon_d  = 8'h01;
          rnd_d   = 4'd0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
`ifdef AES_OUT_REG_EN
        // One extra RUN cycle after round 10 copies the result out.
        if (rnd_q == 4'd10) begin
          out_d = state_q;
          fsm_d = DONE;
        end else begin
          state_d = rounds_state;
          rkey_d  = rounds_key;
          rcon_d  = rounds_rcon;
          rnd_d   = rnd_q + 4'(UNROLL);
        end
`else
        state_d = rounds_state;
        rkey_d  = rounds_key;
        rcon_d  = rounds_rcon;
        rnd_d   = rnd_q + 4'(UNROLL);
        if (rnd_q + 4'(UNROLL) == 4'd10) fsm_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Control and visible-output state: cleared by reset.
  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
`ifdef AES_OUT_REG_EN
      out_q   <= '0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
`ifdef AES_OUT_REG_EN
      out_q   <= out_d;
`endif
    end
  end

  // Key schedule state: always reloaded on acceptance, so no reset needed.
  always_ff @(posedge CLK) begin
    rkey_q <= rkey_d;
    rcon_q <= rcon_d;
    rnd_q  <= rnd_d;
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
`ifdef AES_OUT_REG_EN
  assign TextOut   = out_q;
`else
  assign TextOut   = state_q;
`endif

endmodule

// File: tb/tb_aes128_cipher_unrolled.sv
// Testbench for aes128_cipher_unrolled: one instance per legal UNROLL value
// (1, 2, 5, 10) sharing KEY/TextIn, each with its own handshake signals.
module tb_aes128_cipher_unrolled;

`ifdef AES_OUT_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic [127:0] key, txt;
  logic [3:0]   in_valid, out_ready;
  logic [3:0]   in_ready, out_valid, busy;
  logic [127:0] text_out [4];

  int checks = 0;
  int errors = 0;

  logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int U = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 5 : 10;
    aes128_cipher_unrolled #(.UNROLL(U)) u_dut (
      .CLK       (clk),
      .Rst_n     (rst_n),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .KEY       (key),
      .TextIn    (txt),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .TextOut   (text_out[i]),
      .busy      (busy[i])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int unr(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 5;
      default: return 10;
    endcase
  endfunction

  function automatic logic [7:0] tsbox(input logic [7:0] x);
    return sbox_tbl[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Reference AES-128: full key expansion first, then ten table-driven rounds.
  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {tsbox(t[23:16]), tsbox(t[15:8]), tsbox(t[7:0]), tsbox(t[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    s = p ^ k;
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) a[j] = tsbox(s[127 - 8*j -: 8]);
      for (int j = 0; j < 16; j++) b[j] = a[(j % 4) + 4*(((j / 4) + (j % 4)) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a[4*c]   = gmul(b[4*c], 8'h02) ^ gmul(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
          a[4*c+1] = b[4*c] ^ gmul(b[4*c+1], 8'h02) ^ gmul(b[4*c+2], 8'h03) ^ b[4*c+3];
          a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2], 8'h02) ^ gmul(b[4*c+3], 8'h03);
          a[4*c+3] = gmul(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3], 8'h02);
        end
      end else begin
        for (int j = 0; j < 16; j++) a[j] = b[j];
      end
      for (int j = 0; j < 16; j++)
        s[127 - 8*j -: 8] = a[j] ^ w[4*r + j/4][31 - 8*(j % 4) -: 8];
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block on DUT idx, then measure latency and check the result.
  // Leaves the DUT in DONE with out_ready low.
  task automatic run_vec(input int idx, input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] e, input string tag);
    int lat;
    chk($sformatf("%s_in_ready", tag), in_ready[idx], 1);
    key = k;
    txt = p;
    in_valid[idx] = 1'b1;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    key = ~k;
    txt = ~p;
    chk($sformatf("%s_busy", tag), busy[idx], 1);
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s_latency", tag), lat, 10 / unr(idx) + EXTRA);
    chk($sformatf("%s_result", tag), text_out[idx], e);
  endtask

  task automatic release_out(input int idx, input string tag);
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    chk($sformatf("%s_rel_out_valid", tag), out_valid[idx], 0);
    chk($sformatf("%s_rel_in_ready", tag), in_ready[idx], 1);
  endtask

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] L_SUB = 128'h7df76b0c1ab899b33e42f047b91b546f;

  initial begin
    logic [127:0] saved;
    logic [127:0] exp_q [$];
    int sent, got, last_acc, cyc;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    key       = '0;
    txt       = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset values
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_in_ready%0d", i), in_ready[i], 1);
      chk($sformatf("rst_out_valid%0d", i), out_valid[i], 0);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_textout%0d", i), text_out[i], 0);
    end

    // FIPS-197 C.1 at UNROLL=1, App. B at 2, 5, 10
    run_vec(0, K_C1, P_C1, C_C1, "c1_u1");
    release_out(0, "c1_u1");
    run_vec(1, K_B, P_B, C_B, "b_u2");
    release_out(1, "b_u2");
    run_vec(2, K_B, P_B, C_B, "b_u5");
    release_out(2, "b_u5");
    run_vec(3, K_B, P_B, C_B, "b_u10");
    release_out(3, "b_u10");

    // CMAC subkey L, then backpressure while in DONE
    run_vec(0, K_B, 128'h0, L_SUB, "cmacL_u1");
    saved = text_out[0];
    for (int c = 0; c < 20; c++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      txt = {$urandom, $urandom, $urandom, $urandom};
      in_valid[0] = c[0];
      @(negedge clk);
      chk($sformatf("bp_textout_c%0d", c), text_out[0], saved);
      chk($sformatf("bp_in_ready_c%0d", c), in_ready[0], 0);
      chk($sformatf("bp_out_valid_c%0d", c), out_valid[0], 1);
    end
    // in_valid and out_ready together: only the output handshake completes
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    chk("bp_rel_out_valid", out_valid[0], 0);
    chk("bp_rel_in_ready", in_ready[0], 1);
    chk("bp_rel_busy", busy[0], 0);
    @(negedge clk);
    chk("bp_no_accept", in_ready[0], 1);

    // Reset mid-RUN at round 4
    key = K_C1;
    txt = P_C1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready[0], 1);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_textout", text_out[0], 0);
    run_vec(0, K_C1, P_C1, C_C1, "c1_after_rst");
    release_out(0, "c1_after_rst");

    // Back-to-back random vectors, out_ready tied high, in_valid held high
    for (int idx = 0; idx < 4; idx++) begin
      exp_q.delete();
      sent = 0;
      got = 0;
      last_acc = 0;
      cyc = 0;
      out_ready[idx] = 1'b1;
      in_valid[idx]  = 1'b1;
      while (got < 8 && cyc < 300) begin
        if (out_valid[idx]) begin
          if (exp_q.size() > 0)
            chk($sformatf("b2b_u%0d_v%0d", unr(idx), got), text_out[idx], exp_q.pop_front());
          else
            chk($sformatf("b2b_u%0d_spurious", unr(idx)), out_valid[idx], 0);
          got++;
        end
        if (in_ready[idx]) begin
          if (sent > 0 && sent < 8)
            chk($sformatf("b2b_u%0d_interval%0d", unr(idx), sent), cyc - last_acc,
                10 / unr(idx) + 2 + EXTRA);
          if (sent < 8) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            txt = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(aes_model(key, txt));
            last_acc = cyc;
            sent++;
          end else begin
            in_valid[idx] = 1'b0;
          end
        end
        @(negedge clk);
        cyc++;
      end
      in_valid[idx]  = 1'b0;
      out_ready[idx] = 1'b0;
      chk($sformatf("b2b_u%0d_count", unr(idx)), got, 8);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
